// File: rtl/period_meter_pkg.sv
// period_meter_pkg: shared types for the period meter.
// Latency: n/a (types only).
// Backpressure: n/a.
package period_meter_pkg;

   // Measurement FSM states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      MEAS = 2'd2
   } pm_state_t;

endpackage

// File: rtl/period_meter_if.sv
// period_meter_if: control input, measured signal and result bundle of the period meter.
// Latency: n/a (wires only).
// Backpressure: none; results are strobed by valid/overflow and must be taken when seen.
interface period_meter_if #(
   parameter int WIDTH = 16
);
   logic             enable;
   logic             sig_in;
   logic [WIDTH-1:0] period;
   logic [WIDTH-1:0] high_time;
   logic             valid;
   logic             overflow;
   logic             locked;

   // The meter drives the results and samples enable/sig_in.
   modport master (
      input  enable, sig_in,
      output period, high_time, valid, overflow, locked
   );

   // The consumer drives enable/sig_in and observes the results.
   modport slave (
      output enable, sig_in,
      input  period, high_time, valid, overflow, locked
   );
endinterface

// File: rtl/period_meter_sync_edge_detect.sv
// sync_edge_detect: synchronises an async input and flags its rising/falling edges.
// Latency: an input change first sampled at edge k shows on level/rise/fall after edge k+SYNC_STAGES-1.
// Backpressure: none; rise/fall are single-cycle pulses.
module sync_edge_detect #(
   parameter int SYNC_STAGES = 2   // must be >= 2 for metastability protection
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise,
   output logic fall,
   output logic level
);
   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   prev_q;
   logic                   prev_d;

   // Shift the raw input along the chain; the extra flop holds the previous synchronised level.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], d};
      prev_d = sync_q[SYNC_STAGES-1];
   end

   // Synchroniser chain and edge-history flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = level & ~prev_q;
   assign fall  = ~level & prev_q;

endmodule

// File: rtl/period_meter.sv
// period_meter: measures period (rise to rise) and high time (rise to fall) of a slow signal in clk cycles.
// Latency: a sig_in rise first sampled at edge k gives valid in the cycle after edge k+SYNC_STAGES.
// Backpressure: none; valid/overflow are single-cycle strobes, results hold until the next update.
module period_meter
   import period_meter_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic           clk,
   input  logic           rst,
   period_meter_if.master bus
);
   // Highest count that still leaves room for one more cycle: 2^WIDTH-2.
   localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

   logic rise;
   logic fall;
   logic sync_level_unused;

   sync_edge_detect #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst   (rst),
      .d     (bus.sig_in),
      .rise  (rise),
      .fall  (fall),
      .level (sync_level_unused)
   );

   pm_state_t        state_q,    state_d;
   logic [WIDTH-1:0] cnt_q,      cnt_d;
   logic [WIDTH-1:0] hshadow_q,  hshadow_d;
   logic [WIDTH-1:0] period_q,   period_d;
   logic [WIDTH-1:0] high_q,     high_d;
   logic             valid_q,    valid_d;
   logic             overflow_q, overflow_d;
   logic             locked_q,   locked_d;
   logic [WIDTH-1:0] cnt_inc;

   // Next-state logic: enable has priority, then rise beats the overflow limit.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      hshadow_d  = hshadow_q;
      period_d   = period_q;
      high_d     = high_q;
      valid_d    = 1'b0;
      overflow_d = 1'b0;
      cnt_inc    = cnt_q + WIDTH'(1);

      if (!bus.enable) begin
         // Results hold across a disable; only the running measurement is discarded.
         state_d   = IDLE;
         cnt_d     = '0;
         hshadow_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               cnt_d   = '0;
               state_d = ARM;
            end
            ARM: begin
               // First rise only starts timing; a full period is needed before reporting.
               cnt_d = '0;
               if (rise) begin
                  state_d = MEAS;
               end
            end
            MEAS: begin
               if (rise) begin
                  // A rise at CNT_LAST is a legal 2^WIDTH-1 period, so it is checked first.
                  period_d = cnt_inc;
                  high_d   = hshadow_q;
                  valid_d  = 1'b1;
                  cnt_d    = '0;
               end else if (cnt_q == CNT_LAST) begin
                  overflow_d = 1'b1;
                  state_d    = ARM;
                  cnt_d      = '0;
               end else begin
                  // The fall cycle still counts towards the period.
                  cnt_d = cnt_inc;
                  if (fall) begin
                     hshadow_d = cnt_inc;
                  end
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end

      locked_d = (state_d == MEAS);
   end

   // FSM, counters and registered outputs; reset clears everything at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         hshadow_q  <= '0;
         period_q   <= '0;
         high_q     <= '0;
         valid_q    <= 1'b0;
         overflow_q <= 1'b0;
         locked_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         hshadow_q  <= hshadow_d;
         period_q   <= period_d;
         high_q     <= high_d;
         valid_q    <= valid_d;
         overflow_q <= overflow_d;
         locked_q   <= locked_d;
      end
   end

   assign bus.period    = period_q;
   assign bus.high_time = high_q;
   assign bus.valid     = valid_q;
   assign bus.overflow  = overflow_q;
   assign bus.locked    = locked_q;

endmodule
